// File: rtl/ex_mult_sched.sv
// EX-stage scheduler. It shares the single ALU between pipeline operands and an
// iterative shift-add MULT/MULTU sequencer that writes a 2*WIDTH-bit product
// into HI/LO.
//
// Handshake: mul_start is accepted only on a posedge where the FSM is IDLE. A
// start seen in any other state is dropped, with no queueing and no error.
// From the cycle after acceptance until done, busy and stall stay high. done is a
// single-cycle pulse, and during that cycle hi/lo already hold the new product.
module ex_mult_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_sel,
    input  logic [WIDTH-1:0] ex_rs,
    input  logic [WIDTH-1:0] ex_rt,
    input  logic [WIDTH-1:0] ex_imm,
    input  logic             mul_start,
    input  logic             mul_signed,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_force_add,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] p_full;
    logic [2*WIDTH-1:0] p_fin;
    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rt;

    // State register. Reset abandons any multiply in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic and ALU operand muxing.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        p_hi_d        = p_hi_q;
        p_lo_d        = p_lo_q;
        mcand_d       = mcand_q;
        neg_d         = neg_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        alu_a         = ex_rs;
        alu_b         = ex_sel ? ex_imm : ex_rt;
        alu_force_add = 1'b0;

        // A magnitude of the most negative value keeps the same bit pattern,
        // which is correct once it is read as unsigned.
        mag_rs = (mul_signed && ex_rs[WIDTH-1]) ? (~ex_rs + WIDTH'(1)) : ex_rs;
        mag_rt = (mul_signed && ex_rt[WIDTH-1]) ? (~ex_rt + WIDTH'(1)) : ex_rt;

        // The sign fix-up negates internally so the ALU is free during SIGN.
        p_full = {p_hi_q, p_lo_q};
        p_fin  = neg_q ? (~p_full + (2*WIDTH)'(1)) : p_full;

        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    mcand_d = mag_rs;
                    p_hi_d  = '0;
                    p_lo_d  = mag_rt;
                    neg_d   = mul_signed & (ex_rs[WIDTH-1] ^ ex_rt[WIDTH-1]);
                    count_d = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                alu_a         = p_hi_q;
                alu_b         = p_lo_q[0] ? mcand_q : '0;
                alu_force_add = 1'b1;
                p_hi_d        = {alu_cout, alu_result[WIDTH-1:1]};
                p_lo_d        = {alu_result[0], p_lo_q[WIDTH-1:1]};
                count_d       = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                p_hi_d  = p_fin[2*WIDTH-1:WIDTH];
                p_lo_d  = p_fin[WIDTH-1:0];
                hi_d    = p_fin[2*WIDTH-1:WIDTH];
                lo_d    = p_fin[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall     = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_mult_sched.sv
// Bench for ex_mult_sched. It models the external ALU as a plain 33-bit adder,
// issues directed multiplies and checks the pipeline handshake timing. A
// done-driven monitor compares each product against a queue of hand-computed
// expected values.
module tb_ex_mult_sched;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          ex_sel;
    logic [W-1:0]  ex_rs;
    logic [W-1:0]  ex_rt;
    logic [W-1:0]  ex_imm;
    logic          mul_start;
    logic          mul_signed;
    logic [W-1:0]  alu_result;
    logic          alu_cout;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_force_add;
    logic          stall;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    ex_mult_sched #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_sel       (ex_sel),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_imm       (ex_imm),
        .mul_start    (mul_start),
        .mul_signed   (mul_signed),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_force_add(alu_force_add),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .dbg_state    (dbg_state)
    );

    // External ALU model: unsigned add with carry out.
    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected product.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual hi=%h lo=%h required no done", hi, lo);
            end else begin
                check("product", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Issue one multiply and check the busy window cycle by cycle. When inject_k
    // is nonzero, a second start with other operands arrives in cycle T+inject_k.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sgn, input logic [63:0] expv, input int inject_k);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = 0;
        @(negedge clk);
        ex_rs      = a;
        ex_rt      = b;
        mul_signed = sgn;
        mul_start  = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (stall !== 1'b1 || busy !== 1'b1 ||
                done !== (k == W + 2) || alu_force_add !== (k <= W) ||
                (k == W + 1 && dbg_state !== 2'd2)) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            if (inject_k != 0 && k == inject_k) begin
                ex_rs      = 32'd100;
                ex_rt      = 32'd200;
                mul_signed = 1'b0;
                mul_start  = 1'b1;
            end else begin
                mul_start = 1'b0;
            end
        end
        check("busy_window_bad_cycle", 64'(first_bad), 64'd0);
        @(negedge clk);
        check("idle_after_done", {61'd0, stall, busy, done}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        ex_sel     = 1'b0;
        ex_rs      = '0;
        ex_rt      = '0;
        ex_imm     = '0;
        mul_start  = 1'b0;
        mul_signed = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_force_add", 64'(alu_force_add), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // IDLE forwarding with the ALUSrc select
        ex_sel = 1'b0; ex_rs = 32'd5; ex_rt = 32'd7; ex_imm = 32'd9;
        #1;
        check("idle_alu_a", 64'(alu_a), 64'd5);
        check("idle_alu_b_rt", 64'(alu_b), 64'd7);
        check("idle_stall", 64'(stall), 64'd0);
        ex_sel = 1'b1;
        #1;
        check("idle_alu_b_imm", 64'(alu_b), 64'd9);
        ex_sel = 1'b0;

        // Directed products
        run_mul(32'd3, 32'd5, 1'b0, 64'h00000000_0000000F, 0);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 0);
        run_mul(32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFFA, 0);
        run_mul(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 0);
        run_mul(32'd7, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFF_FFFFFFF9, 0);
        run_mul(32'hFFFFFFFB, 32'hFFFFFFFA, 1'b1, 64'h00000000_0000001E, 0);
        // A start while busy is ignored, so the result comes from the first operands.
        run_mul(32'd6, 32'd7, 1'b0, 64'h00000000_0000002A, 10);
        check("no_pending_after_inject", 64'(exp_q.size()), 64'd0);

        // Reset mid-multiply: no done, and HI/LO are cleared.
        @(negedge clk);
        ex_rs = 32'd9; ex_rt = 32'd11; mul_signed = 1'b0; mul_start = 1'b1;
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        repeat (40) @(negedge clk);
        check("midrst_still_idle", {62'd0, stall, done}, 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
